// File: rtl/robo_wall_follower.sv
`default_nettype none
// ============================================================================
// Module   : robo_wall_follower
// Brief    : Prescaled wall-following FSM (search / rotate / follow / corner).
// Revision : 1.0
// ============================================================================
module robo_wall_follower #(
   parameter int DIV        = 2,
   parameter int TURN_MAX   = 8,
   parameter int CORNER_MAX = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       side_sel,
   input  logic       head,
   input  logic       left,
   input  logic       right,
   output logic       avancar,
   output logic       girar,
   output logic       dir_giro,
   output logic       stuck,
   output logic [2:0] state,
   output logic       step_tick
);

   localparam logic [2:0] c_idle   = 3'd0;
   localparam logic [2:0] c_search = 3'd1;
   localparam logic [2:0] c_rotate = 3'd2;
   localparam logic [2:0] c_follow = 3'd3;
   localparam logic [2:0] c_corner = 3'd4;
   localparam logic [2:0] c_stuck  = 3'd5;

   localparam logic [7:0] c_div_last    = 8'(DIV - 1);
   localparam logic [7:0] c_turn_last   = 8'(TURN_MAX - 1);
   localparam logic [7:0] c_corner_last = 8'(CORNER_MAX - 1);

   logic [2:0] r_state;
   logic [7:0] r_pcnt;
   logic [7:0] r_turn_cnt;
   logic [7:0] r_corner_cnt;
   logic       r_side_q;

   logic       w_tick;
   logic       w_wall;
   logic [2:0] w_state_nxt;
   logic [7:0] w_turn_nxt;
   logic [7:0] w_corner_nxt;

   assign w_tick = enable & (r_pcnt == c_div_last);
   assign w_wall = r_side_q ? right : left;

   // Sensor-driven exits are tested before the counter limits so they win ties.
   always_comb begin
      w_state_nxt  = r_state;
      w_turn_nxt   = r_turn_cnt;
      w_corner_nxt = r_corner_cnt;
      case (r_state)
         c_idle: begin
            if (w_tick) w_state_nxt = c_search;
         end
         c_search: begin
            if (w_tick) begin
               if (head) begin
                  w_state_nxt = c_rotate;
                  w_turn_nxt  = 8'd0;
               end else if (w_wall) begin
                  w_state_nxt = c_follow;
               end
            end
         end
         c_rotate: begin
            if (w_tick) begin
               if (!head && w_wall)             w_state_nxt = c_follow;
               else if (r_turn_cnt == c_turn_last) w_state_nxt = c_stuck;
               else                             w_turn_nxt  = r_turn_cnt + 8'd1;
            end
         end
         c_follow: begin
            if (w_tick) begin
               if (head) begin
                  w_state_nxt = c_rotate;
                  w_turn_nxt  = 8'd0;
               end else if (!w_wall) begin
                  w_state_nxt  = c_corner;
                  w_corner_nxt = 8'd0;
               end
            end
         end
         c_corner: begin
            if (w_tick) begin
               if (head) begin
                  w_state_nxt = c_rotate;
                  w_turn_nxt  = 8'd0;
               end else if (w_wall) begin
                  w_state_nxt = c_follow;
               end else if (r_corner_cnt == c_corner_last) begin
                  w_state_nxt = c_search;
               end else begin
                  w_corner_nxt = r_corner_cnt + 8'd1;
               end
            end
         end
         c_stuck: begin
            w_state_nxt = c_stuck;
         end
         default: begin
            w_state_nxt = c_idle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= c_idle;
         r_pcnt       <= 8'd0;
         r_turn_cnt   <= 8'd0;
         r_corner_cnt <= 8'd0;
         r_side_q     <= 1'b0;
      end else if (!enable) begin
         r_state      <= c_idle;
         r_pcnt       <= 8'd0;
         r_turn_cnt   <= 8'd0;
         r_corner_cnt <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_turn_cnt   <= w_turn_nxt;
         r_corner_cnt <= w_corner_nxt;
         r_pcnt       <= w_tick ? 8'd0 : r_pcnt + 8'd1;
         // The followed side is frozen once the robot commits to a wall.
         if (w_tick && (r_state == c_idle || r_state == c_search))
            r_side_q <= side_sel;
      end
   end

   always_comb begin
      avancar  = 1'b0;
      girar    = 1'b0;
      dir_giro = 1'b0;
      stuck    = 1'b0;
      case (r_state)
         c_search: avancar = 1'b1;
         c_follow: avancar = 1'b1;
         c_rotate: begin
            girar    = 1'b1;
            dir_giro = ~r_side_q;
         end
         c_corner: begin
            girar    = 1'b1;
            dir_giro = r_side_q;
         end
         c_stuck:  stuck = 1'b1;
         default: ;
      endcase
   end

   assign state     = r_state;
   assign step_tick = w_tick;

endmodule
`default_nettype wire
